// File: rtl/proc_pkg.sv
// Shared definitions for the proc RV32I core: opcode and funct3/funct7
// encodings, MRET encoding, ALU operation and FSM state enums, and the
// ALU-op decode helper used by the top level.
package proc_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0]  F7_ALT     = 7'b0100000;
  localparam logic [31:0] INSTR_MRET = 32'h3020_0073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_FETCH_WAIT, S_EXEC, S_MEM, S_MEM_WAIT, S_IRQ
  } state_e;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/proc_if.sv
// Memory and interrupt bus of the proc core.
// master = core side, slave = SoC shell side (memories, IRQ controller).
//   instr_*: fetch request/grant/valid port
//   data_*:  load/store request/grant/valid port
//   irq, irq_id / irq_ack, irq_ack_id: level interrupt and acknowledge
interface proc_if;
  logic        instr_req;
  logic [31:0] instr_adr;
  logic        instr_gnt;
  logic        instr_r_valid;
  logic [31:0] instr_read_in;
  logic        data_req;
  logic [31:0] data_adr;
  logic        data_write_enable;
  logic [31:0] data_write;
  logic        data_gnt;
  logic        data_r_valid;
  logic [31:0] data_read;
  logic        irq;
  logic [4:0]  irq_id;
  logic        irq_ack;
  logic [4:0]  irq_ack_id;

  modport master (
    output instr_req, instr_adr,
    input  instr_gnt, instr_r_valid, instr_read_in,
    output data_req, data_adr, data_write_enable, data_write,
    input  data_gnt, data_r_valid, data_read,
    input  irq, irq_id,
    output irq_ack, irq_ack_id
  );

  modport slave (
    input  instr_req, instr_adr,
    output instr_gnt, instr_r_valid, instr_read_in,
    input  data_req, data_adr, data_write_enable, data_write,
    output data_gnt, data_r_valid, data_read,
    output irq, irq_id,
    input  irq_ack, irq_ack_id
  );
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU of the proc core.
// Ports: a, b (operands), op (operation) -> result, plus compare flags
// eq (a==b), lt (signed a<b), ltu (unsigned a<b) for branch resolution.
module proc_alu
  import proc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);
  logic [4:0] shamt;

  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/proc.sv
// proc: multi-cycle RV32I core, one instruction at a time.
// Ports: clk (core clock), res (async active-low reset),
//        bus (proc_if.master: fetch port, load/store port, irq/ack).
// Optional feature macro IRQ_EN: level interrupts taken at instruction
// boundaries with one-cycle acknowledge, mepc/ie state and MRET.
// Without IRQ_EN, irq/irq_id are ignored and MRET is a NOP.
//
// state        | meaning
// S_FETCH      | instr_req=1 with instr_adr=PC until instr_gnt
// S_FETCH_WAIT | wait instr_r_valid, latch instruction
// S_EXEC       | decode, ALU, writeback, next PC
// S_MEM        | data_req=1 with address/data/we until data_gnt
// S_MEM_WAIT   | wait data_r_valid, loads write rd
// S_IRQ        | acknowledge interrupt, save PC, jump to vector
module proc
  import proc_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC_BASE = 32'h0000_0000
) (
  input logic    clk,
  input logic    res,
  proc_if.master bus
);
  state_e      state, state_nxt;
  logic [31:0] pc, ir, pc_plus4, pc_nxt;
  logic [31:0] rf [32];
  logic [31:0] mem_adr, mem_wdata, mem_adr_nxt;
  logic        mem_we, mem_we_nxt, is_mem, wb_en, br_taken, irq_take;
  logic [31:0] wb_data;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
  logic [31:0] alu_b, alu_result;
  logic        alu_alt, alu_eq, alu_lt, alu_ltu;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  // rf[0] is reset to zero and never written, so x0 reads 0
  assign rs1_val  = rf[rs1];
  assign rs2_val  = rf[rs2];
  assign pc_plus4 = pc + 32'd4;

  // OP-IMM only has an alternate encoding for SRAI; ADDI never subtracts
  assign alu_alt = (opcode == OPC_OP) ? ir[30] : (ir[30] && funct3 == F3_SR);
  assign alu_b   = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_val : imm_i;

  proc_alu u_alu (
    .a      (rs1_val),
    .b      (alu_b),
    .op     (alu_op_decode(funct3, alu_alt)),
    .result (alu_result),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

`ifdef IRQ_EN
  logic        ie;
  logic [31:0] mepc;
  assign irq_take = bus.irq && ie;
`else
  logic unused_irq;
  assign unused_irq = ^{bus.irq, bus.irq_id};
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = alu_eq;
      F3_BNE:  br_taken = !alu_eq;
      F3_BLT:  br_taken = alu_lt;
      F3_BGE:  br_taken = !alu_lt;
      F3_BLTU: br_taken = alu_ltu;
      F3_BGEU: br_taken = !alu_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt      = pc_plus4;
    wb_en       = 1'b0;
    wb_data     = alu_result;
    is_mem      = 1'b0;
    mem_we_nxt  = 1'b0;
    mem_adr_nxt = rs1_val + imm_i;
    case (opcode)
      OPC_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
      OPC_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u; end
      OPC_JAL:    begin wb_en = 1'b1; wb_data = pc_plus4; pc_nxt = pc + imm_j; end
      OPC_JALR:   begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_nxt  = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: if (br_taken) pc_nxt = pc + imm_b;
      OPC_OP_IMM, OPC_OP: wb_en = 1'b1;
      OPC_LOAD:   is_mem = 1'b1;
      OPC_STORE:  begin is_mem = 1'b1; mem_we_nxt = 1'b1; mem_adr_nxt = rs1_val + imm_s; end
      OPC_SYSTEM: begin
`ifdef IRQ_EN
        if (ir == INSTR_MRET) pc_nxt = mepc;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:      if (bus.instr_gnt) state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: if (bus.instr_r_valid) state_nxt = S_EXEC;
      S_EXEC:       state_nxt = is_mem ? S_MEM : (irq_take ? S_IRQ : S_FETCH);
      S_MEM:        if (bus.data_gnt) state_nxt = S_MEM_WAIT;
      S_MEM_WAIT:   if (bus.data_r_valid) state_nxt = irq_take ? S_IRQ : S_FETCH;
      S_IRQ:        state_nxt = S_FETCH;
      default:      state_nxt = S_FETCH;
    endcase
  end

  // Outputs are gated by res so they drop the instant reset asserts,
  // including the S_FETCH request that would otherwise show during reset.
  always_comb begin
    bus.instr_req         = 1'b0;
    bus.instr_adr         = '0;
    bus.data_req          = 1'b0;
    bus.data_adr          = '0;
    bus.data_write        = '0;
    bus.data_write_enable = 1'b0;
    bus.irq_ack           = 1'b0;
    bus.irq_ack_id        = '0;
    if (res) begin
      case (state)
        S_FETCH: begin
          bus.instr_req = 1'b1;
          bus.instr_adr = pc;
        end
        S_MEM: begin
          bus.data_req          = 1'b1;
          bus.data_adr          = mem_adr;
          bus.data_write        = mem_wdata;
          bus.data_write_enable = mem_we;
        end
        S_IRQ: begin
`ifdef IRQ_EN
          bus.irq_ack    = 1'b1;
          bus.irq_ack_id = bus.irq_id;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pc        <= BOOT_ADDR;
      ir        <= '0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
`ifdef IRQ_EN
      ie   <= 1'b1;
      mepc <= '0;
`endif
    end else begin
      case (state)
        S_FETCH_WAIT: if (bus.instr_r_valid) ir <= bus.instr_read_in;
        S_EXEC: begin
          pc        <= pc_nxt;
          mem_adr   <= mem_adr_nxt;
          mem_wdata <= rs2_val;
          mem_we    <= mem_we_nxt;
          if (wb_en && rd != 5'd0) rf[rd] <= wb_data;
`ifdef IRQ_EN
          if (ir == INSTR_MRET) ie <= 1'b1;
`endif
        end
        S_MEM_WAIT: if (bus.data_r_valid && !mem_we && rd != 5'd0) rf[rd] <= bus.data_read;
        S_IRQ: begin
`ifdef IRQ_EN
          mepc <= pc;
          ie   <= 1'b0;
          pc   <= IRQ_VEC_BASE + {25'b0, bus.irq_id, 2'b0};
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_proc.sv
module tb_proc;
  logic clk = 1'b0;
  logic res = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  proc_if bus();
  proc dut (.clk(clk), .res(res), .bus(bus));

  // memory-side helpers: they only drive the bus and report what they saw
  task automatic serve_fetch(input logic [31:0] word, output logic [31:0] adr, output bit ok);
    ok  = 1'b0;
    adr = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.instr_req) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    adr = bus.instr_adr;
    bus.instr_gnt = 1'b1;
    @(posedge clk); #1;
    bus.instr_gnt     = 1'b0;
    bus.instr_r_valid = 1'b1;
    bus.instr_read_in = word;
    @(posedge clk); #1;
    bus.instr_r_valid = 1'b0;
  endtask

  task automatic serve_data(input logic [31:0] rdata, input int delay, output logic [31:0] adr,
                            output logic [31:0] wdat, output logic we, output bit stable, output bit ok);
    ok = 1'b0; stable = 1'b1; adr = '0; wdat = '0; we = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.data_req) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    adr  = bus.data_adr;
    wdat = bus.data_write;
    we   = bus.data_write_enable;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (!bus.data_req || bus.data_adr !== adr || bus.data_write !== wdat ||
          bus.data_write_enable !== we) stable = 1'b0;
    end
    bus.data_gnt = 1'b1;
    @(posedge clk); #1;
    bus.data_gnt     = 1'b0;
    bus.data_r_valid = 1'b1;
    bus.data_read    = rdata;
    @(posedge clk); #1;
    bus.data_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (bus.instr_req !== 1'b0) begin fails++; $display("FAIL reset_instr_req got %0b want 0", bus.instr_req); end
    tests++; if (bus.instr_adr !== 32'h0) begin fails++; $display("FAIL reset_instr_adr got %h want 0", bus.instr_adr); end
    tests++; if (bus.data_req !== 1'b0) begin fails++; $display("FAIL reset_data_req got %0b want 0", bus.data_req); end
    tests++; if (bus.irq_ack !== 1'b0) begin fails++; $display("FAIL reset_irq_ack got %0b want 0", bus.irq_ack); end
    @(posedge clk); #1;
    res = 1'b1;
  endtask

  task automatic test_addi();
    logic [31:0] adr;
    bit ok;
    serve_fetch(32'h0050_0093, adr, ok);  // ADDI x1,x0,5
    tests++; if (!ok || adr !== 32'h0) begin fails++; $display("FAIL addi_fetch0 got %h ok=%0b want 0", adr, ok); end
    serve_fetch(32'hFF90_8113, adr, ok);  // ADDI x2,x1,-7
    tests++; if (!ok || adr !== 32'h4) begin fails++; $display("FAIL addi_fetch1 got %h ok=%0b want 4", adr, ok); end
    @(posedge clk); #1;
    tests++; if (dut.rf[1] !== 32'h5) begin fails++; $display("FAIL addi_x1 got %h want 5", dut.rf[1]); end
    tests++; if (dut.rf[2] !== 32'hFFFF_FFFE) begin fails++; $display("FAIL addi_x2 got %h want fffffffe", dut.rf[2]); end
  endtask

  task automatic test_load_store();
    logic [31:0] adr, dadr, dwd;
    logic dwe;
    bit ok, stable;
    serve_fetch(32'h0020_2423, adr, ok);  // SW x2,8(x0)
    tests++; if (!ok || adr !== 32'h8) begin fails++; $display("FAIL sw_fetch got %h want 8", adr); end
    serve_data(32'h0, 3, dadr, dwd, dwe, stable, ok);
    tests++; if (!ok || dadr !== 32'h8) begin fails++; $display("FAIL sw_adr got %h ok=%0b want 8", dadr, ok); end
    tests++; if (dwd !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sw_data got %h want fffffffe", dwd); end
    tests++; if (dwe !== 1'b1) begin fails++; $display("FAIL sw_we got %0b want 1", dwe); end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL sw_stable got %0b want 1", stable); end
    serve_fetch(32'h0080_2183, adr, ok);  // LW x3,8(x0)
    tests++; if (!ok || adr !== 32'hC) begin fails++; $display("FAIL lw_fetch got %h want c", adr); end
    serve_data(32'h1234_5678, 0, dadr, dwd, dwe, stable, ok);
    tests++; if (!ok || dadr !== 32'h8 || dwe !== 1'b0) begin fails++; $display("FAIL lw_req adr %h we %0b want 8/0", dadr, dwe); end
    tests++; if (dut.rf[3] !== 32'h1234_5678) begin fails++; $display("FAIL lw_x3 got %h want 12345678", dut.rf[3]); end
  endtask

  task automatic test_branch();
    // BNE x1,x2,-8 / ADDI x4,x0,-1 / ADDI x5,x0,1 / BLT x4,x5,8 / BLTU x4,x5,8
    logic [31:0] prog [5] = '{32'hFE20_9CE3, 32'hFFF0_0213, 32'h0010_0293, 32'h0052_4463, 32'h0052_6463};
    logic [31:0] exp  [5] = '{32'h10, 32'h08, 32'h0C, 32'h10, 32'h18};
    logic [31:0] adr;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      serve_fetch(prog[i], adr, ok);
      tests++; if (!ok || adr !== exp[i]) begin fails++; $display("FAIL branch_fetch%0d got %h want %h", i, adr, exp[i]); end
    end
  endtask

  task automatic test_jalr();
    // ADDI x5,x0,0x101 / JALR x1,4(x5) / ADDI x0,x0,9
    logic [31:0] prog [3] = '{32'h1010_0293, 32'h0042_80E7, 32'h0090_0013};
    logic [31:0] exp  [3] = '{32'h1C, 32'h20, 32'h104};
    logic [31:0] adr;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      serve_fetch(prog[i], adr, ok);
      tests++; if (!ok || adr !== exp[i]) begin fails++; $display("FAIL jalr_fetch%0d got %h want %h", i, adr, exp[i]); end
    end
    @(posedge clk); #1;
    tests++; if (dut.rf[1] !== 32'h24) begin fails++; $display("FAIL jalr_link got %h want 24", dut.rf[1]); end
    tests++; if (dut.rf[0] !== 32'h0) begin fails++; $display("FAIL x0_write got %h want 0", dut.rf[0]); end
  endtask

  task automatic test_alu_ops();
    // LUI x7,0x80000 / SRA x6,x7,x1 / SLTU x8,x5,x7 / SUB x10,x5,x7 / JAL x11,-24 / AUIPC x12,1
    logic [31:0] prog [6] = '{32'h8000_03B7, 32'h4013_D333, 32'h0072_B433, 32'h4072_8533,
                              32'hFE9F_F5EF, 32'h0000_1617};
    logic [31:0] exp  [6] = '{32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h100};
    logic [31:0] adr;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      serve_fetch(prog[i], adr, ok);
      tests++; if (!ok || adr !== exp[i]) begin fails++; $display("FAIL alu_fetch%0d got %h want %h", i, adr, exp[i]); end
    end
    @(posedge clk); #1;
    tests++; if (dut.rf[7] !== 32'h8000_0000) begin fails++; $display("FAIL lui got %h want 80000000", dut.rf[7]); end
    tests++; if (dut.rf[6] !== 32'hF800_0000) begin fails++; $display("FAIL sra got %h want f8000000", dut.rf[6]); end
    tests++; if (dut.rf[8] !== 32'h1) begin fails++; $display("FAIL sltu got %h want 1", dut.rf[8]); end
    tests++; if (dut.rf[10] !== 32'h8000_0101) begin fails++; $display("FAIL sub got %h want 80000101", dut.rf[10]); end
    tests++; if (dut.rf[11] !== 32'h11C) begin fails++; $display("FAIL jal_link got %h want 11c", dut.rf[11]); end
    tests++; if (dut.rf[12] !== 32'h1100) begin fails++; $display("FAIL auipc got %h want 1100", dut.rf[12]); end
  endtask

  task automatic test_irq();
    logic [31:0] adr;
    bit ok;
    serve_fetch(32'h0000_0013, adr, ok);  // NOP at 0x104
    tests++; if (!ok || adr !== 32'h104) begin fails++; $display("FAIL irq_nop_fetch got %h want 104", adr); end
    bus.irq    = 1'b1;
    bus.irq_id = 5'd3;
    @(negedge clk);
    @(negedge clk);
`ifdef IRQ_EN
    tests++; if (bus.irq_ack !== 1'b1 || bus.irq_ack_id !== 5'd3) begin fails++; $display("FAIL irq_ack got %0b/%0d want 1/3", bus.irq_ack, bus.irq_ack_id); end
    @(negedge clk);
    tests++; if (bus.irq_ack !== 1'b0) begin fails++; $display("FAIL irq_ack_len got %0b want 0", bus.irq_ack); end
    serve_fetch(32'h3020_0073, adr, ok);  // MRET in handler, irq still held
    tests++; if (!ok || adr !== 32'h0C) begin fails++; $display("FAIL irq_vector got %h want c", adr); end
    @(negedge clk);
    @(negedge clk);
    tests++; if (bus.irq_ack !== 1'b0) begin fails++; $display("FAIL irq_retaken got %0b want 0", bus.irq_ack); end
`else
    tests++; if (bus.irq_ack !== 1'b0 || bus.irq_ack_id !== 5'd0) begin fails++; $display("FAIL irq_ignored got %0b/%0d want 0/0", bus.irq_ack, bus.irq_ack_id); end
`endif
    bus.irq = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.instr_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!ok || bus.instr_adr !== 32'h108) begin fails++; $display("FAIL irq_resume got %h ok=%0b want 108", bus.instr_adr, ok); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] adr;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.instr_req) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL rst_mid_req got 0 want 1"); end
    bus.instr_gnt = 1'b1;
    @(posedge clk); #1;
    bus.instr_gnt = 1'b0;
    res = 1'b0;
    #1;
    tests++; if (bus.instr_req !== 1'b0 || bus.instr_adr !== 32'h0) begin fails++; $display("FAIL rst_mid_out req %0b adr %h want 0/0", bus.instr_req, bus.instr_adr); end
    tests++; if (dut.rf[2] !== 32'h0) begin fails++; $display("FAIL rst_mid_rf got %h want 0", dut.rf[2]); end
    @(negedge clk);
    tests++; if (bus.instr_req !== 1'b0) begin fails++; $display("FAIL rst_hold_req got %0b want 0", bus.instr_req); end
    @(posedge clk); #1;
    res = 1'b1;
    serve_fetch(32'h0000_0013, adr, ok);
    tests++; if (!ok || adr !== 32'h0) begin fails++; $display("FAIL rst_restart got %h ok=%0b want 0", adr, ok); end
  endtask

  initial begin
    bus.instr_gnt     = 1'b0;
    bus.instr_r_valid = 1'b0;
    bus.instr_read_in = '0;
    bus.data_gnt      = 1'b0;
    bus.data_r_valid  = 1'b0;
    bus.data_read     = '0;
    bus.irq           = 1'b0;
    bus.irq_id        = '0;
    test_reset();
    test_addi();
    test_load_store();
    test_branch();
    test_jalr();
    test_alu_ops();
    test_irq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d tests", tests);
    $fatal(1, "watchdog");
  end
endmodule
